// File: rtl/iterative_divider.sv
// Multi-cycle signed divider: restoring division on operand magnitudes, one quotient bit per cycle, then sign fix-up.
// Optional signed remainder output enabled by defining DIV_REMAINDER_EN.
module iterative_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             data_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? neg(v) : v;
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] rem_r;
  logic             sign_q_r;
  logic             zero_r;
`ifdef DIV_REMAINDER_EN
  logic             sign_rem_r;
`endif

  logic [WIDTH:0]   shifted_s;
  logic             borrow_s;
  logic [WIDTH-1:0] next_rem_s;

  // Trial subtraction of the divisor magnitude from the shifted partial remainder.
  always_comb begin
    shifted_s = {rem_r, quo_r[WIDTH-1]};
    borrow_s  = (shifted_s < {1'b0, div_r});
    if (borrow_s) begin
      next_rem_s = shifted_s[WIDTH-1:0];
    end else begin
      next_rem_s = shifted_s[WIDTH-1:0] - div_r;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      cnt_r          <= CNT_ZERO;
      quo_r          <= ZERO_W;
      div_r          <= ZERO_W;
      rem_r          <= ZERO_W;
      sign_q_r       <= 1'b0;
      zero_r         <= 1'b0;
      data_result    <= ZERO_W;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      data_busy      <= 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_rem_r     <= 1'b0;
      data_remainder <= ZERO_W;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          data_resultRDY <= 1'b0;
          if (ctrl_DIV) begin
            quo_r          <= mag(data_operandA);
            div_r          <= mag(data_operandB);
            sign_q_r       <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            rem_r          <= ZERO_W;
            cnt_r          <= CNT_ZERO;
            zero_r         <= (data_operandB == ZERO_W);
            data_exception <= 1'b0;
            data_busy      <= 1'b1;
`ifdef DIV_REMAINDER_EN
            sign_rem_r     <= data_operandA[WIDTH-1];
`endif
            // Divide-by-zero spends one cycle in SIGN so DONE lands on the next edge.
            state_r        <= (data_operandB == ZERO_W) ? SIGN : ITER;
          end else begin
            state_r <= IDLE;
          end
        end
        ITER: begin
          rem_r <= next_rem_s;
          quo_r <= {quo_r[WIDTH-2:0], ~borrow_s};
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= SIGN;
          end else begin
            state_r <= ITER;
          end
        end
        SIGN: begin
          if (zero_r) begin
            data_result    <= ZERO_W;
            data_exception <= 1'b1;
`ifdef DIV_REMAINDER_EN
            data_remainder <= ZERO_W;
`endif
          end else begin
            data_result    <= sign_q_r ? neg(quo_r) : quo_r;
            // A positive quotient magnitude of 2**(WIDTH-1) is not representable.
            data_exception <= ~sign_q_r & quo_r[WIDTH-1];
`ifdef DIV_REMAINDER_EN
            data_remainder <= sign_rem_r ? neg(rem_r) : rem_r;
`endif
          end
          data_resultRDY <= 1'b1;
          state_r        <= DONE;
        end
        DONE: begin
          data_resultRDY <= 1'b0;
          data_busy      <= 1'b0;
          state_r        <= IDLE;
        end
        default: begin
          data_resultRDY <= 1'b0;
          data_busy      <= 1'b0;
          state_r        <= IDLE;
        end
      endcase
    end
  end

endmodule
